// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
package mouse_pkg;

    // Packet assembly states: await header, await dx, await dy.
    typedef enum logic [1:0] {
        StB0 = 2'd0,
        StB1 = 2'd1,
        StB2 = 2'd2
    } mouse_state_e;

    localparam int unsigned ScreenWDefault = 640;
    localparam int unsigned ScreenHDefault = 480;

    // Bit positions inside the PS/2 header byte.
    localparam int unsigned HdrBtnL  = 0;
    localparam int unsigned HdrBtnR  = 1;
    localparam int unsigned HdrSync  = 3;
    localparam int unsigned HdrXSign = 4;
    localparam int unsigned HdrYSign = 5;
    localparam int unsigned HdrXOvf  = 6;
    localparam int unsigned HdrYOvf  = 7;

    // Signed width used for position arithmetic; wide enough that pos +/- 256 never wraps.
    localparam int unsigned PosSumW = 12;

    // Header fields the tracker actually consumes.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic btn_r;
        logic btn_l;
    } mouse_hdr_t;

    function automatic mouse_hdr_t unpack_hdr(input logic [7:0] b);
        mouse_hdr_t h;
        h.y_ovf  = b[HdrYOvf];
        h.x_ovf  = b[HdrXOvf];
        h.y_sign = b[HdrYSign];
        h.x_sign = b[HdrXSign];
        h.btn_r  = b[HdrBtnR];
        h.btn_l  = b[HdrBtnL];
        return h;
    endfunction

    // 9-bit two's complement movement; an overflow flag discards the movement entirely.
    function automatic logic signed [8:0] movement(input logic sign, input logic [7:0] mag,
                                                   input logic ovf);
        return ovf ? 9'sd0 : $signed({sign, mag});
    endfunction

endpackage

// File: rtl/mouse_pos_accum.sv
// Saturating position update: pos_o = clamp(pos_i + delta_i, 0, limit_i).
module mouse_pos_accum
    import mouse_pkg::*;
#(
    parameter int unsigned PosW = 10
) (
    input  logic [PosW-1:0]           pos_i,
    input  logic signed [PosSumW-1:0] delta_i,
    input  logic [PosW-1:0]           limit_i,
    output logic [PosW-1:0]           pos_o
);

    logic signed [PosSumW-1:0] pos_ext;
    logic signed [PosSumW-1:0] lim_ext;
    logic signed [PosSumW-1:0] sum;

    // Widen to signed, add, then clamp to [0, limit].
    always_comb begin
        pos_ext = $signed({{(PosSumW - PosW){1'b0}}, pos_i});
        lim_ext = $signed({{(PosSumW - PosW){1'b0}}, limit_i});
        sum     = pos_ext + delta_i;
        if (sum[PosSumW-1]) begin
            pos_o = '0;
        end else if (sum > lim_ext) begin
            pos_o = limit_i;
        end else begin
            pos_o = sum[PosW-1:0];
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet assembler and cursor tracker with inter-byte timeout.
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned SCREEN_W    = ScreenWDefault,
    parameter int unsigned SCREEN_H    = ScreenHDefault,
    parameter int unsigned INIT_X      = 320,
    parameter int unsigned INIT_Y      = 240,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic       btn_l,
    output logic       btn_r,
    output logic       l_click,
    output logic       r_click,
    output logic       pkt_valid,
    output logic       sync_err
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [9:0]     XLimit  = 10'(SCREEN_W - 1);
    localparam logic [8:0]     YLimit  = 9'(SCREEN_H - 1);

    mouse_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    mouse_hdr_t        hdr_q, hdr_d;
    logic [7:0]        dx_byte_q, dx_byte_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              btn_l_q, btn_l_d;
    logic              btn_r_q, btn_r_d;
    logic              l_click_q, l_click_d;
    logic              r_click_q, r_click_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              sync_err_q, sync_err_d;

    logic              commit;
    logic              drop;
    logic              timeout;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic signed [PosSumW-1:0] dx_ext;
    logic signed [PosSumW-1:0] dy_neg;
    logic [9:0]        x_new;
    logic [8:0]        y_new;

    // Packet FSM and idle counter; a byte in the expiry cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        dx_byte_d = dx_byte_q;
        commit    = 1'b0;
        drop      = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            StB0: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data[HdrSync]) begin
                        hdr_d   = unpack_hdr(rx_data);
                        state_d = StB1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            StB1, StB2: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == StB1) begin
                        dx_byte_d = rx_data;
                        state_d   = StB2;
                    end else begin
                        commit  = 1'b1;
                        state_d = StB0;
                    end
                end else if (cnt_q == CntLast) begin
                    timeout = 1'b1;
                    cnt_d   = '0;
                    state_d = StB0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StB0;
                cnt_d   = '0;
            end
        endcase
    end

    // Movement deltas; y is negated because PS/2 y grows upward and screen y downward.
    always_comb begin
        dx     = movement(hdr_q.x_sign, dx_byte_q, hdr_q.x_ovf);
        dy     = movement(hdr_q.y_sign, rx_data, hdr_q.y_ovf);
        dx_ext = {{(PosSumW - 9){dx[8]}}, dx};
        dy_neg = -{{(PosSumW - 9){dy[8]}}, dy};
    end

    mouse_pos_accum #(
        .PosW (10)
    ) u_acc_x (
        .pos_i   (x_q),
        .delta_i (dx_ext),
        .limit_i (XLimit),
        .pos_o   (x_new)
    );

    mouse_pos_accum #(
        .PosW (9)
    ) u_acc_y (
        .pos_i   (y_q),
        .delta_i (dy_neg),
        .limit_i (YLimit),
        .pos_o   (y_new)
    );

    // Registered outputs: position/buttons load on commit, pulses last one cycle.
    always_comb begin
        x_d         = commit ? x_new : x_q;
        y_d         = commit ? y_new : y_q;
        btn_l_d     = commit ? hdr_q.btn_l : btn_l_q;
        btn_r_d     = commit ? hdr_q.btn_r : btn_r_q;
        l_click_d   = commit & hdr_q.btn_l & ~btn_l_q;
        r_click_d   = commit & hdr_q.btn_r & ~btn_r_q;
        pkt_valid_d = commit;
        sync_err_d  = drop | timeout;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StB0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            dx_byte_q   <= '0;
            x_q         <= 10'(INIT_X);
            y_q         <= 9'(INIT_Y);
            btn_l_q     <= 1'b0;
            btn_r_q     <= 1'b0;
            l_click_q   <= 1'b0;
            r_click_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            dx_byte_q   <= dx_byte_d;
            x_q         <= x_d;
            y_q         <= y_d;
            btn_l_q     <= btn_l_d;
            btn_r_q     <= btn_r_d;
            l_click_q   <= l_click_d;
            r_click_q   <= r_click_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign mouse_x   = x_q;
    assign mouse_y   = y_q;
    assign btn_l     = btn_l_q;
    assign btn_r     = btn_r_q;
    assign l_click   = l_click_q;
    assign r_click   = r_click_q;
    assign pkt_valid = pkt_valid_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Self-checking bench for mouse_tracker: directed scenarios plus randomized byte streams.
module tb_mouse_tracker;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] mouse_x;
    logic [8:0] mouse_y;
    logic       btn_l, btn_r, l_click, r_click, pkt_valid, sync_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cursor, buttons, bytes of the packet in flight, idle cycles.
    int         m_x, m_y;
    bit         m_bl, m_br;
    logic [7:0] m_pkt[$];
    int         m_idle;
    bit         e_lc, e_rc, e_pv, e_se;

    mouse_tracker #(
        .SCREEN_W    (640),
        .SCREEN_H    (480),
        .INIT_X      (320),
        .INIT_Y      (240),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mouse_x   (mouse_x),
        .mouse_y   (mouse_y),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .l_click   (l_click),
        .r_click   (r_click),
        .pkt_valid (pkt_valid),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 240; m_bl = 0; m_br = 0;
        m_pkt.delete(); m_idle = 0;
        e_lc = 0; e_rc = 0; e_pv = 0; e_se = 0;
    endtask

    task automatic model_commit();
        logic [7:0] h;
        int dx, dy;
        h  = m_pkt[0];
        dx = h[6] ? 0 : (int'(m_pkt[1]) - (h[4] ? 256 : 0));
        dy = h[7] ? 0 : (int'(m_pkt[2]) - (h[5] ? 256 : 0));
        m_x  = clamp(m_x + dx, 639);
        m_y  = clamp(m_y - dy, 479);
        e_lc = h[0] && !m_bl;
        e_rc = h[1] && !m_br;
        m_bl = h[0];
        m_br = h[1];
        e_pv = 1;
        m_pkt.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        e_lc = 0; e_rc = 0; e_pv = 0; e_se = 0;
        if (v) begin
            m_idle = 0;
            if (m_pkt.size() == 0 && !d[3]) begin
                e_se = 1;
            end else begin
                m_pkt.push_back(d);
                if (m_pkt.size() == 3) model_commit();
            end
        end else if (m_pkt.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_pkt.delete();
                m_idle = 0;
                e_se = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("mouse_x", 16'(mouse_x), 16'(m_x));
        chk("mouse_y", 16'(mouse_y), 16'(m_y));
        chk("btn_l", 16'(btn_l), 16'(m_bl));
        chk("btn_r", 16'(btn_r), 16'(m_br));
        chk("l_click", 16'(l_click), 16'(e_lc));
        chk("r_click", 16'(r_click), 16'(e_rc));
        chk("pkt_valid", 16'(pkt_valid), 16'(e_pv));
        chk("sync_err", 16'(sync_err), 16'(e_se));
    endtask

    // One clock cycle: drive, let the edge pass, advance the model, compare.
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        model_step(v, d);
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        rx_valid = 0;
        @(posedge clk);
        #2 rst = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        rst      = 1;
        rx_valid = 0;
        rx_data  = 8'h00;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1;

        // Idle after reset: nothing moves, no pulses.
        idle(100);

        // Basic packet with left press, then the same packet again.
        send(8'h09); send(8'h05); send(8'h03);
        chk("r19_x", 16'(mouse_x), 16'd325);
        chk("r19_y", 16'(mouse_y), 16'd237);
        chk("r19_click", 16'(l_click), 16'd1);
        chk("r19_pv", 16'(pkt_valid), 16'd1);
        idle(1);
        chk("r19_pv_low", 16'(pkt_valid), 16'd0);
        send(8'h09); send(8'h05); send(8'h03);
        chk("r19b_x", 16'(mouse_x), 16'd330);
        chk("r19b_y", 16'(mouse_y), 16'd234);
        chk("r19b_click", 16'(l_click), 16'd0);

        // Negative clamp on x.
        do_reset();
        send(8'h18); send(8'h00); send(8'h00);
        chk("r20_x64", 16'(mouse_x), 16'd64);
        send(8'h18); send(8'h00); send(8'h00);
        chk("r20_x0", 16'(mouse_x), 16'd0);

        // Positive clamp on x.
        do_reset();
        send(8'h08); send(8'hFF); send(8'h00);
        chk("r20_x575", 16'(mouse_x), 16'd575);
        send(8'h08); send(8'hFF); send(8'h00);
        chk("r20_x639a", 16'(mouse_x), 16'd639);
        send(8'h08); send(8'hFF); send(8'h00);
        chk("r20_x639b", 16'(mouse_x), 16'd639);

        // Dropped header byte.
        do_reset();
        send(8'h00);
        chk("r21_sync", 16'(sync_err), 16'd1);
        send(8'h08); send(8'h01); send(8'h00);
        chk("r21_x", 16'(mouse_x), 16'd321);

        // Timeout discards a partial packet.
        do_reset();
        send(8'h08); send(8'h10);
        idle(T - 1);
        chk("r22_pre", 16'(sync_err), 16'd0);
        idle(1);
        chk("r22_sync", 16'(sync_err), 16'd1);
        chk("r22_nocommit", 16'(pkt_valid), 16'd0);
        send(8'h08); send(8'h01); send(8'h00);
        chk("r22_x", 16'(mouse_x), 16'd321);

        // Byte arriving exactly in the expiry cycle is accepted.
        do_reset();
        send(8'h08);
        idle(T - 1);
        send(8'h01);
        chk("r12_nosync", 16'(sync_err), 16'd0);
        send(8'h00);
        chk("r12_pv", 16'(pkt_valid), 16'd1);
        chk("r12_x", 16'(mouse_x), 16'd321);

        // X overflow flag suppresses dx.
        do_reset();
        send(8'h48); send(8'h7F); send(8'h01);
        chk("r23_x", 16'(mouse_x), 16'd320);
        chk("r23_y", 16'(mouse_y), 16'd239);
        chk("r23_pv", 16'(pkt_valid), 16'd1);

        // Reset mid-packet: next byte is treated as a header.
        do_reset();
        send(8'h08); send(8'h10);
        do_reset();
        send(8'h00);
        chk("r15_sync", 16'(sync_err), 16'd1);
        send(8'h08); send(8'h01); send(8'h00);
        chk("r15_x", 16'(mouse_x), 16'd321);

        // Randomized byte streams with occasional gaps around the timeout.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            int gap;
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 2, T + 2))
                                              : int'($urandom_range(0, 2));
            idle(gap);
            d    = 8'($urandom);
            d[3] = ($urandom_range(0, 5) != 0);
            send(d);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
